systolic_skew_feeder: RTL

//   Producer side of the systolic matrix-multiply array interface. Accepts K beats, each one

---
 rtl/systolic_skew_feeder_pkg.sv | 16 +
 rtl/systolic_skew_feeder_if.sv | 27 ++
 rtl/systolic_skew_feeder_skew_delay_line.sv | 28 ++
 rtl/systolic_skew_feeder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types for the systolic array interface: feeder FSM states and the lane element type.
package systolic_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DONE
  } feeder_state_e;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Job control and beat stream between a producer (master) and the skew feeder (slave).
interface systolic_skew_feeder_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 256,
  parameter int unsigned KW     = 16
);

  logic                         Start;
  logic [KW-1:0]                K;
  logic                         Busy;
  logic                         Done;
  logic                         In_Valid;
  logic                         In_Ready;
  logic [LENGTH-1:0][WIDTH-1:0] In_Act;
  logic [LENGTH-1:0][WIDTH-1:0] In_Wgt;

  modport master (
    output Start, K, In_Valid, In_Act, In_Wgt,
    input  Busy, Done, In_Ready
  );

  modport slave (
    input  Start, K, In_Valid, In_Act, In_Wgt,
    output Busy, Done, In_Ready
  );

endinterface

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// DEPTH-stage shift register with shift enable and synchronous clear (clear wins).
module skew_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (clear) begin
      stage <= '0;
    end else if (shift) begin
      stage[0] <= din;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews K activation/weight beats into a diagonal wavefront for the systolic array, then flushes.
// Optional SKEW_FEEDER_STATS_EN adds a saturating Stall_Count output.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LENGTH       = 256,
  parameter int unsigned KW           = 16,
  parameter int unsigned FLUSH_CYCLES = 2*LENGTH-1
) (
  input  logic                         CLK,
  input  logic                         SYNC_RST_N,
  systolic_skew_feeder_if.slave        bus,
  output logic [LENGTH-1:0][WIDTH-1:0] Arr_Inputs,
  output logic [LENGTH-1:0][WIDTH-1:0] Arr_Weights,
  output logic                         Arr_EN,
  output logic                         Arr_SYNC_RST
`ifdef SKEW_FEEDER_STATS_EN
  ,
  output logic [31:0]                  Stall_Count
`endif
);

  localparam int unsigned FCW = $clog2(FLUSH_CYCLES+1);

  feeder_state_e state, state_next;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  beat_cnt;
  logic [FCW-1:0] flush_cnt;
  logic           advance;
  logic           en_q;
  logic           done_q;
  logic           skew_clear;

  always_ff @(posedge CLK) begin
    if (!SYNC_RST_N) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    unique case (state)
      IDLE:  if (bus.Start) state_next = CLEAR;
      CLEAR: state_next = (k_q == '0) ? FLUSH : FEED;
      FEED: begin
        if (bus.In_Valid) begin
          advance = 1'b1;
          if (beat_cnt == k_q - 1'b1) state_next = FLUSH;
        end
      end
      FLUSH: begin
        advance = 1'b1;
        if (flush_cnt == FCW'(FLUSH_CYCLES-1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Done and Arr_EN are both registered, so the pulse lands after the final enabled step
  // has been consumed by the array and never overlaps Arr_EN.
  always_ff @(posedge CLK) begin
    if (!SYNC_RST_N) begin
      k_q       <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      en_q   <= advance;
      done_q <= (state == DONE);
      if (state == IDLE && bus.Start) k_q <= bus.K;
      if (state == CLEAR)                beat_cnt <= '0;
      else if (state == FEED && advance) beat_cnt <= beat_cnt + 1'b1;
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else                flush_cnt <= '0;
    end
  end

  assign bus.Busy     = (state != IDLE);
  assign bus.Done     = done_q;
  assign bus.In_Ready = (state == FEED);
  assign Arr_EN       = en_q;
  assign Arr_SYNC_RST = (state == CLEAR);
  assign skew_clear   = !SYNC_RST_N || (state == CLEAR);

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    logic [WIDTH-1:0] act_in, wgt_in;

    assign act_in = (state == FEED) ? bus.In_Act[i] : '0;
    assign wgt_in = (state == FEED) ? bus.In_Wgt[i] : '0;

    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i+1)) u_act (
      .clk   (CLK),
      .clear (skew_clear),
      .shift (advance),
      .din   (act_in),
      .dout  (Arr_Inputs[i])
    );

    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i+1)) u_wgt (
      .clk   (CLK),
      .clear (skew_clear),
      .shift (advance),
      .din   (wgt_in),
      .dout  (Arr_Weights[i])
    );
  end

`ifdef SKEW_FEEDER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge CLK) begin
    if (!SYNC_RST_N)                                         stall_q <= '0;
    else if (state == CLEAR)                                 stall_q <= '0;
    else if (state == FEED && !bus.In_Valid && stall_q != '1) stall_q <= stall_q + 1'b1;
  end

  assign Stall_Count = stall_q;
`endif

endmodule
